multi_pwm: RTL and testbench

MULTI_PWM -- requirements
Module: multi_pwm

---
 rtl/pwm_if.sv | 26 ++
 rtl/multi_pwm.sv | 131 +++++++++++++
 tb/tb_multi_pwm.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_if.sv
// Control/status bundle for multi_pwm: run controls and duty loading in, PWM and counter status out.
interface pwm_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int PRESC_W  = 8
);
  logic                      en;
  logic                      mode;
  logic [PRESC_W-1:0]        prescale;
  logic [CHANNELS*WIDTH-1:0] duty_in;
  logic                      duty_wr;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_start;
  logic [WIDTH-1:0]          cnt;
  logic                      dir;

  modport master (
    output en, mode, prescale, duty_in, duty_wr,
    input  pwm_out, period_start, cnt, dir
  );

  modport slave (
    input  en, mode, prescale, duty_in, duty_wr,
    output pwm_out, period_start, cnt, dir
  );
endinterface

// File: rtl/multi_pwm.sv
// Multi-channel PWM with shared prescaled counter (sawtooth or triangle) and
// double-buffered duties that only change at period boundaries.
module multi_pwm #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int PRESC_W  = 8
) (
  input  logic  clk,
  input  logic  rst,
  pwm_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} state_t;

  state_t                    state_reg, state_next;
  logic [PRESC_W-1:0]        presc_reg;
  logic [WIDTH-1:0]          cnt_reg, cnt_next;
  logic                      mode_reg;
  logic                      first_reg;
  logic                      period_start_reg;
  logic                      tick;
  logic                      boundary;
  logic [CHANNELS*WIDTH-1:0] shadow_reg;
  logic [CHANNELS*WIDTH-1:0] active_reg;
  logic [CHANNELS-1:0]       pwm_reg;

  // >= rather than == so a prescale lowered below the running count ticks at once.
  assign tick = bus.en && (presc_reg >= bus.prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= UP;
    else if (!bus.en)
      state_reg <= UP;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    boundary   = 1'b0;
    if (tick) begin
      if (first_reg) begin
        boundary   = 1'b1;
        cnt_next   = '0;
        state_next = UP;
      end else if (!mode_reg) begin
        cnt_next   = cnt_reg + 1'b1;
        state_next = UP;
        boundary   = (cnt_reg == MAX);
      end else begin
        case (state_reg)
          UP: begin
            if (cnt_reg >= MAX - 1'b1) begin
              cnt_next   = MAX;
              state_next = DOWN;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          DOWN: begin
            if (cnt_reg <= 1) begin
              cnt_next   = '0;
              state_next = UP;
              boundary   = 1'b1;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
          default: state_next = UP;
        endcase
      end
    end
  end

  // first_reg makes the first tick after enable/reset act as a period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg        <= '0;
      cnt_reg          <= '0;
      mode_reg         <= 1'b0;
      first_reg        <= 1'b1;
      period_start_reg <= 1'b0;
      shadow_reg       <= '0;
    end else begin
      if (bus.duty_wr)
        shadow_reg <= bus.duty_in;
      if (!bus.en) begin
        presc_reg        <= '0;
        cnt_reg          <= '0;
        first_reg        <= 1'b1;
        period_start_reg <= 1'b0;
      end else begin
        presc_reg        <= tick ? '0 : presc_reg + 1'b1;
        cnt_reg          <= cnt_next;
        period_start_reg <= boundary;
        if (boundary) begin
          first_reg <= 1'b0;
          mode_reg  <= bus.mode;
        end
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    // A write landing on the boundary bypasses the shadow so it is not lost for a period.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        active_reg[gi*WIDTH +: WIDTH] <= '0;
      else if (boundary)
        active_reg[gi*WIDTH +: WIDTH] <= bus.duty_wr ? bus.duty_in[gi*WIDTH +: WIDTH]
                                                     : shadow_reg[gi*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        pwm_reg[gi] <= 1'b0;
      else if (!bus.en)
        pwm_reg[gi] <= 1'b0;
      else
        pwm_reg[gi] <= (cnt_reg < active_reg[gi*WIDTH +: WIDTH]);
    end
  end

  assign bus.pwm_out      = pwm_reg;
  assign bus.period_start = period_start_reg;
  assign bus.cnt          = cnt_reg;
  assign bus.dir          = (state_reg == DOWN);
endmodule

// File: tb/tb_multi_pwm.sv
// Self-checking bench for multi_pwm: period-level reference model checked every cycle,
// a table of duty/mode/prescale vectors, targeted corner sequences and random stimulus.
module tb_multi_pwm;
  localparam int W   = 8;
  localparam int CH  = 3;
  localparam int PW  = 8;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  pwm_if #(.WIDTH(W), .CHANNELS(CH), .PRESC_W(PW)) bus ();

  multi_pwm #(.WIDTH(W), .CHANNELS(CH), .PRESC_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase index within the current period, plus duty buffers.
  int m_presc, m_p, m_mode, m_first, m_ps, m_pwm;
  int m_active [CH];
  int m_shadow [CH];

  typedef struct {
    int presc; int mode; int d0; int d1; int d2;
    int win;   int h0;   int h1; int h2;
  } vec_t;
  vec_t vecs [4];

  function automatic int m_cnt();
    if (m_mode != 0 && m_first == 0)
      return (m_p <= MAX) ? m_p : 2 * MAX - m_p;
    return m_p;
  endfunction

  function automatic int m_dir();
    return (m_mode != 0 && m_first == 0 && m_p >= MAX) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_p = 0; m_mode = 0; m_first = 1; m_ps = 0; m_pwm = 0;
    for (int k = 0; k < CH; k++) begin
      m_active[k] = 0;
      m_shadow[k] = 0;
    end
  endtask

  task automatic model_next();
    int duty [CH];
    int c, npwm, plen;
    bit tick, bnd;
    for (int k = 0; k < CH; k++) duty[k] = int'(bus.duty_in[k*W +: W]);
    if (!bus.en) begin
      m_presc = 0; m_p = 0; m_first = 1; m_pwm = 0; m_ps = 0;
      if (bus.duty_wr) for (int k = 0; k < CH; k++) m_shadow[k] = duty[k];
      return;
    end
    tick = (m_presc >= int'(bus.prescale));
    c = m_cnt();
    npwm = 0;
    for (int k = 0; k < CH; k++) if (c < m_active[k]) npwm |= (1 << k);
    bnd = 1'b0;
    if (tick) begin
      plen = (m_mode != 0) ? 2 * MAX : MAX + 1;
      if (m_first != 0 || m_p == plen - 1) bnd = 1'b1;
      else m_p++;
    end
    if (bnd) begin
      m_p = 0; m_mode = int'(bus.mode); m_first = 0;
      for (int k = 0; k < CH; k++) m_active[k] = bus.duty_wr ? duty[k] : m_shadow[k];
    end
    if (bus.duty_wr) for (int k = 0; k < CH; k++) m_shadow[k] = duty[k];
    m_presc = tick ? 0 : m_presc + 1;
    m_ps  = bnd ? 1 : 0;
    m_pwm = npwm;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("cnt", int'(bus.cnt), m_cnt());
    chk("dir", int'(bus.dir), m_dir());
    chk("period_start", int'(bus.period_start), m_ps);
    chk("pwm_out", int'(bus.pwm_out), m_pwm);
  endtask

  task automatic step();
    model_next();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.en = 1'b0; bus.duty_wr = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2);
    bus.duty_in = {W'(d2), W'(d1), W'(d0)};
    bus.duty_wr = 1'b1;
    step();
    bus.duty_wr = 1'b0;
  endtask

  task automatic wait_ps(input int limit);
    int n = 0;
    while (!bus.period_start && n < limit) begin
      step();
      n++;
    end
    if (!bus.period_start) chk("period_start_timeout", 0, 1);
  endtask

  task automatic wait_cnt(input int value, input int limit);
    int n = 0;
    while (int'(bus.cnt) != value && n < limit) begin
      step();
      n++;
    end
    if (int'(bus.cnt) != value) chk("cnt_wait_timeout", int'(bus.cnt), value);
  endtask

  task automatic measure(input int n, output int h0, output int h1, output int h2, output int nps);
    h0 = 0; h1 = 0; h2 = 0; nps = 0;
    for (int i = 0; i < n; i++) begin
      h0 += int'(bus.pwm_out[0]);
      h1 += int'(bus.pwm_out[1]);
      h2 += int'(bus.pwm_out[2]);
      nps += int'(bus.period_start);
      step();
    end
  endtask

  initial begin
    int h0, h1, h2, nps;
    rst = 1'b1;
    bus.en = 1'b0; bus.mode = 1'b0; bus.prescale = '0; bus.duty_in = '0; bus.duty_wr = 1'b0;
    model_reset();

    vecs[0] = '{presc: 0, mode: 0, d0: 64,  d1: 0,   d2: 255, win: 256,  h0: 64,  h1: 0,   h2: 255};
    vecs[1] = '{presc: 0, mode: 1, d0: 128, d1: 0,   d2: 255, win: 510,  h0: 255, h1: 0,   h2: 509};
    vecs[2] = '{presc: 3, mode: 0, d0: 64,  d1: 128, d2: 255, win: 1024, h0: 256, h1: 512, h2: 1020};
    vecs[3] = '{presc: 1, mode: 1, d0: 10,  d1: 1,   d2: 200, win: 1020, h0: 38,  h1: 2,   h2: 798};

    #1;
    chk("reset_cnt", int'(bus.cnt), 0);
    chk("reset_pwm", int'(bus.pwm_out), 0);
    chk("reset_ps", int'(bus.period_start), 0);
    chk("reset_dir", int'(bus.dir), 0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      bus.mode = vecs[v].mode[0];
      bus.prescale = PW'(vecs[v].presc);
      set_duty(vecs[v].d0, vecs[v].d1, vecs[v].d2);
      bus.en = 1'b1;
      wait_ps(3000);
      step();
      wait_ps(3000);
      measure(vecs[v].win, h0, h1, h2, nps);
      chk($sformatf("vec%0d_ch0_high", v), h0, vecs[v].h0);
      chk($sformatf("vec%0d_ch1_high", v), h1, vecs[v].h1);
      chk($sformatf("vec%0d_ch2_high", v), h2, vecs[v].h2);
      chk($sformatf("vec%0d_period_starts", v), nps, 1);
    end

    // Duty written mid-period must wait for the boundary.
    do_reset();
    bus.mode = 1'b0; bus.prescale = '0;
    set_duty(50, 0, 0);
    bus.en = 1'b1;
    wait_ps(600);
    step();
    wait_ps(600);
    wait_cnt(100, 300);
    set_duty(200, 0, 0);
    h0 = 0;
    for (int i = 0; i < 300 && !bus.period_start; i++) begin
      h0 += int'(bus.pwm_out[0]);
      step();
    end
    chk("late_write_held_low", h0, 0);
    measure(256, h0, h1, h2, nps);
    chk("late_write_new_high", h0, 200);

    // Mode change mid-period: sawtooth finishes, triangle starts at 0.
    wait_cnt(50, 300);
    bus.mode = 1'b1;
    step();
    wait_ps(300);
    chk("mode_switch_cnt0", int'(bus.cnt), 0);
    for (int i = 0; i < 255; i++) step();
    chk("tri_peak_cnt", int'(bus.cnt), 255);
    chk("tri_peak_dir", int'(bus.dir), 1);

    // Asynchronous reset mid-period.
    bus.mode = 1'b0;
    set_duty(90, 90, 90);
    wait_cnt(120, 1200);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", int'(bus.cnt), 0);
    chk("async_rst_pwm", int'(bus.pwm_out), 0);
    chk("async_rst_ps", int'(bus.period_start), 0);
    chk("async_rst_dir", int'(bus.dir), 0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    measure(600, h0, h1, h2, nps);
    chk("post_rst_all_low", h0 + h1 + h2, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 20000; i++) begin
      bus.duty_wr = ($urandom_range(0, 99) == 0);
      if (bus.duty_wr) bus.duty_in = CH*W'($urandom);
      if ($urandom_range(0, 199) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 299) == 0) bus.prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) bus.en = ~bus.en;
      step();
    end
    bus.duty_wr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
